capture_sequencer: RTL and testbench

// - Issues multi-frame capture bursts on the camera-link capture path: drives camera select and capture trigger, then tracks each frame to DMA end.
// - Sits between the software register block and the camera capture top. Replaces direct software toggling of cameraSel/new_capture.
// - Supports hawk-only, owl-only or alternating bursts, with settle time, inter-frame gap, start timeout and abort.

---
 rtl/camera_pkg.sv | 41 ++++
 rtl/cap_cycle_timer.sv | 39 +++
 rtl/capture_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// ---------------------------------------------------------------------------
// camera_pkg
// Shared types for the camera-link capture sequencer.
//   cap_state_e : sequencer FSM states (also driven out on the debug port)
//   cap_mode_e  : burst camera-selection modes, encoded as cfg_mode
//   CAM_HAWK / CAM_OWL : camera_sel values
// ---------------------------------------------------------------------------
package camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_TRIGGER    = 3'd3,
    ST_WAIT_START = 3'd4,
    ST_WAIT_DONE  = 3'd5,
    ST_GAP        = 3'd6,
    ST_FINISH     = 3'd7
  } cap_state_e;

  typedef enum logic [1:0] {
    MODE_HAWK     = 2'd0,
    MODE_OWL      = 2'd1,
    MODE_ALT_HAWK = 2'd2,
    MODE_ALT_OWL  = 2'd3
  } cap_mode_e;

  localparam logic CAM_HAWK = 1'b0;
  localparam logic CAM_OWL  = 1'b1;

  // Camera used for the first frame of a burst.
  function automatic logic first_sel(input cap_mode_e mode);
    return ((mode == MODE_OWL) || (mode == MODE_ALT_OWL)) ? CAM_OWL : CAM_HAWK;
  endfunction

  // Alternating modes flip the camera after every frame.
  function automatic logic is_alt(input cap_mode_e mode);
    return (mode == MODE_ALT_HAWK) || (mode == MODE_ALT_OWL);
  endfunction

endpackage

// File: rtl/cap_cycle_timer.sv
// ---------------------------------------------------------------------------
// cap_cycle_timer
// Loadable 32-bit up-counter with enable and a terminal-match flag.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   i_load, i_load_val : load the counter (has priority over i_en)
//   i_en             : count up by one per cycle
//   i_match          : number of cycles to measure
//   o_match          : high in the cycle that completes i_match cycles since
//                      the load (count+1 >= i_match); stays high afterwards,
//                      and is high immediately when i_match is 0
// ---------------------------------------------------------------------------
module cap_cycle_timer (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_en,
  input  logic [31:0] i_match,
  output logic        o_match
);

  logic [31:0] r_count;
  logic [32:0] w_elapsed;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  // Widened so the compare never wraps at the top of the range.
  assign w_elapsed = {1'b0, r_count} + 33'd1;
  assign o_match   = (w_elapsed >= {1'b0, i_match});

endmodule

// File: rtl/capture_sequencer.sv
// ---------------------------------------------------------------------------
// capture_sequencer
// Issues multi-frame capture bursts: drives camera select and the capture
// trigger, then tracks each frame through to the end of its DMA.
//
// Ports
//   sys_clk, sys_rst        : clock, asynchronous active-high reset
//   i_start                 : 1-cycle pulse, begin a burst (ignored while busy)
//   i_abort                 : 1-cycle pulse, stop the burst after the current frame
//   i_cfg_frames/mode/gap/start_timeout : burst config, latched at start
//   i_serde_locked          : PHY lock
//   i_camera_in_progress    : capture path busy
//   i_dma_last              : tlast & tvalid & tready of the S2MM stream
//   o_camera_sel            : 0 = hawk, 1 = owl (held after the burst)
//   o_new_capture           : trigger level, high for TRIG_CYCLES per frame
//   o_busy / o_done         : burst active / 1-cycle end-of-burst pulse
//   o_aborted               : sticky until next start
//   o_frames_ok/failed      : saturating frame counters
//   o_last_frame_ts/cycles  : frame timing (only with FRAME_TIMING_EN)
//   o_state                 : debug view of the FSM state
//
// Signalling: there is no valid/ready handshake on this block. i_start and
// i_abort are single-cycle pulses sampled on every rising edge; o_done is a
// single-cycle pulse; all other outputs are levels.
//
// Build option: define FRAME_TIMING_EN to build the free-running timestamp
// and frame-length capture; otherwise both timing outputs are tied to 0.
// ---------------------------------------------------------------------------
module capture_sequencer
  import camera_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TRIG_CYCLES   = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_cfg_frames,
  input  logic [1:0]       i_cfg_mode,
  input  logic [31:0]      i_cfg_gap,
  input  logic [31:0]      i_cfg_start_timeout,
  input  logic             i_serde_locked,
  input  logic             i_camera_in_progress,
  input  logic             i_dma_last,
  output logic             o_camera_sel,
  output logic             o_new_capture,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_frames_ok,
  output logic [CNT_W-1:0] o_frames_failed,
  output logic [31:0]      o_last_frame_ts,
  output logic [31:0]      o_last_frame_cycles,
  output cap_state_e       o_state
);

  cap_state_e       r_state, w_next_state;
  cap_mode_e        r_cfg_mode;
  logic [CNT_W-1:0] r_cfg_frames, r_frames_ok, r_frames_failed, r_frames_done;
  logic [31:0]      r_cfg_gap, r_cfg_tmo;
  logic             r_camera_sel, r_frame_sel;
  logic             r_abort_pend, r_aborted, r_dma_seen;
  logic [7:0]       r_trig_cnt;

  logic        w_timer_load, w_timer_hit;
  logic [31:0] w_timer_match;
  logic        w_burst_start, w_frame_ok, w_frame_fail;

  // One timer serves settle, start timeout and gap. It is loaded when leaving
  // SELECT, so the start timeout covers SETTLE + TRIGGER + WAIT_START.
  cap_cycle_timer u_timer (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i_load     (w_timer_load),
    .i_load_val (32'd0),
    .i_en       (1'b1),
    .i_match    (w_timer_match),
    .o_match    (w_timer_hit)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_timer_load  = 1'b0;
    w_timer_match = r_cfg_gap;
    w_burst_start = 1'b0;
    w_frame_ok    = 1'b0;
    w_frame_fail  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_cfg_frames == '0) begin
            w_next_state = ST_FINISH;
          end else begin
            w_next_state  = ST_SELECT;
            w_burst_start = 1'b1;
          end
        end
      end
      ST_SELECT: begin
        if (i_abort) begin
          w_next_state = ST_FINISH;
        end else begin
          w_timer_load = 1'b1;
          if ((r_frame_sel == r_camera_sel) && !i_camera_in_progress) begin
            w_next_state = ST_TRIGGER;
          end else begin
            w_next_state = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        w_timer_match = 32'(SETTLE_CYCLES);
        if (i_abort) begin
          w_next_state = ST_FINISH;
        end else if (w_timer_hit && i_serde_locked && !i_camera_in_progress) begin
          w_next_state = ST_TRIGGER;
        end
      end
      ST_TRIGGER: begin
        if (r_trig_cnt == 8'(TRIG_CYCLES - 1)) begin
          w_next_state = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        w_timer_match = r_cfg_tmo;
        // Level test also catches a rise that happened during TRIGGER.
        if (i_camera_in_progress) begin
          w_next_state = ST_WAIT_DONE;
        end else if ((r_cfg_tmo != '0) && w_timer_hit) begin
          w_frame_fail = 1'b1;
          w_timer_load = 1'b1;
          w_next_state = ST_GAP;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_camera_in_progress) begin
          w_frame_ok   = r_dma_seen || i_dma_last;
          w_frame_fail = !(r_dma_seen || i_dma_last);
          w_timer_load = 1'b1;
          w_next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (i_abort) begin
          w_next_state = ST_FINISH;
        end else if (w_timer_hit) begin
          if ((r_frames_done == r_cfg_frames) || r_abort_pend) begin
            w_next_state = ST_FINISH;
          end else begin
            w_next_state = ST_SELECT;
          end
        end
      end
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cfg_mode      <= MODE_HAWK;
      r_cfg_frames    <= '0;
      r_cfg_gap       <= '0;
      r_cfg_tmo       <= '0;
      r_camera_sel    <= CAM_HAWK;
      r_frame_sel     <= CAM_HAWK;
      r_frames_ok     <= '0;
      r_frames_failed <= '0;
      r_frames_done   <= '0;
      r_abort_pend    <= 1'b0;
      r_aborted       <= 1'b0;
      r_dma_seen      <= 1'b0;
      r_trig_cnt      <= '0;
    end else begin
      if (w_burst_start) begin
        r_cfg_mode      <= cap_mode_e'(i_cfg_mode);
        r_cfg_frames    <= i_cfg_frames;
        r_cfg_gap       <= i_cfg_gap;
        r_cfg_tmo       <= i_cfg_start_timeout;
        r_frame_sel     <= first_sel(cap_mode_e'(i_cfg_mode));
        r_frames_ok     <= '0;
        r_frames_failed <= '0;
        r_frames_done   <= '0;
        r_abort_pend    <= 1'b0;
        r_aborted       <= 1'b0;
      end

      if ((r_state == ST_SELECT) && (w_next_state == ST_SETTLE)) begin
        r_camera_sel <= r_frame_sel;
      end

      r_trig_cnt <= (r_state == ST_TRIGGER) ? r_trig_cnt + 8'd1 : 8'd0;

      if (r_state == ST_WAIT_DONE) begin
        if (i_dma_last) r_dma_seen <= 1'b1;
      end else begin
        r_dma_seen <= 1'b0;
      end

      if (w_frame_ok && (r_frames_ok != '1)) begin
        r_frames_ok <= r_frames_ok + CNT_W'(1);
      end
      if (w_frame_fail && (r_frames_failed != '1)) begin
        r_frames_failed <= r_frames_failed + CNT_W'(1);
      end
      // Failed frames advance the alternation too.
      if (w_frame_ok || w_frame_fail) begin
        r_frames_done <= r_frames_done + CNT_W'(1);
        if (is_alt(r_cfg_mode)) r_frame_sel <= ~r_frame_sel;
      end

      if (i_abort && (r_state != ST_IDLE)) begin
        r_aborted <= 1'b1;
      end
      // Mid-frame aborts wait for GAP so no DMA is cut short.
      if (i_abort && ((r_state == ST_TRIGGER) || (r_state == ST_WAIT_START) ||
                      (r_state == ST_WAIT_DONE))) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

`ifdef FRAME_TIMING_EN
  logic [31:0] r_ts, r_rise_ts, r_last_ts, r_last_cycles;
  logic        r_cip_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ts          <= '0;
      r_rise_ts     <= '0;
      r_last_ts     <= '0;
      r_last_cycles <= '0;
      r_cip_d       <= 1'b0;
    end else begin
      r_ts    <= r_ts + 32'd1;
      r_cip_d <= i_camera_in_progress;
      if (i_camera_in_progress && !r_cip_d) begin
        r_rise_ts <= r_ts;
        r_last_ts <= r_ts;
      end
      if (!i_camera_in_progress && r_cip_d) begin
        r_last_cycles <= r_ts - r_rise_ts;
      end
    end
  end

  assign o_last_frame_ts     = r_last_ts;
  assign o_last_frame_cycles = r_last_cycles;
`else
  assign o_last_frame_ts     = '0;
  assign o_last_frame_cycles = '0;
`endif

  assign o_camera_sel    = r_camera_sel;
  assign o_new_capture   = (r_state == ST_TRIGGER);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = (r_state == ST_FINISH);
  assign o_aborted       = r_aborted;
  assign o_frames_ok     = r_frames_ok;
  assign o_frames_failed = r_frames_failed;
  assign o_state         = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_capture_sequencer
// Directed bench for capture_sequencer: a simple camera model answers each
// trigger, a monitor records triggers/selects/done pulses, and each test
// compares those records against hand-derived expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_capture_sequencer;
  import camera_pkg::*;

  localparam int CNT_W = 16;

  // clock / reset
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic             i_start, i_abort, i_serde_locked, i_camera_in_progress, i_dma_last;
  logic [CNT_W-1:0] i_cfg_frames;
  logic [1:0]       i_cfg_mode;
  logic [31:0]      i_cfg_gap, i_cfg_start_timeout;
  logic             o_camera_sel, o_new_capture, o_busy, o_done, o_aborted;
  logic [CNT_W-1:0] o_frames_ok, o_frames_failed;
  logic [31:0]      o_last_frame_ts, o_last_frame_cycles;
  cap_state_e       o_state;

  capture_sequencer #(.SETTLE_CYCLES(16), .TRIG_CYCLES(4), .CNT_W(CNT_W)) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .i_start             (i_start),
    .i_abort             (i_abort),
    .i_cfg_frames        (i_cfg_frames),
    .i_cfg_mode          (i_cfg_mode),
    .i_cfg_gap           (i_cfg_gap),
    .i_cfg_start_timeout (i_cfg_start_timeout),
    .i_serde_locked      (i_serde_locked),
    .i_camera_in_progress(i_camera_in_progress),
    .i_dma_last          (i_dma_last),
    .o_camera_sel        (o_camera_sel),
    .o_new_capture       (o_new_capture),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_aborted           (o_aborted),
    .o_frames_ok         (o_frames_ok),
    .o_frames_failed     (o_frames_failed),
    .o_last_frame_ts     (o_last_frame_ts),
    .o_last_frame_cycles (o_last_frame_cycles),
    .o_state             (o_state)
  );

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // test control shared with the model and monitor
  int   epoch = 0;
  int   start_cyc = 0;
  logic model_en = 1'b1;
  int   model_delay = 5;
  int   model_len = 100;
  int   dma_plan[0:7];   // per frame: 0 none, 1 on last high cycle, 2 on fall cycle

  // camera model: answers each new_capture rise with an in_progress window
  int   mdl_seen = 0, m_phase = 0, m_cnt = 0, m_idx = 0;
  logic m_prev_nc = 1'b0;
  initial begin
    i_camera_in_progress = 1'b0;
    i_dma_last           = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (mdl_seen != epoch) begin
        m_idx    = 0;
        mdl_seen = epoch;
      end
      i_dma_last = 1'b0;
      case (m_phase)
        0: if (model_en && o_new_capture && !m_prev_nc) begin
             m_phase = 1;
             m_cnt   = model_delay;
           end
        1: if (m_cnt == 0) begin
             i_camera_in_progress = 1'b1;
             m_phase = 2;
             m_cnt   = model_len - 1;
           end else begin
             m_cnt--;
           end
        default: if (m_cnt == 0) begin
             i_camera_in_progress = 1'b0;
             i_dma_last = (dma_plan[m_idx & 7] == 2);
             m_idx++;
             m_phase = 0;
           end else begin
             m_cnt--;
             i_dma_last = (m_cnt == 0) && (dma_plan[m_idx & 7] == 1);
           end
      endcase
      m_prev_nc = o_new_capture;
    end
  end

  // monitor
  int         mon_seen = 0;
  int         trig_cnt = 0, done_cnt = 0, done_cyc = 0, first_rise_cyc = 0;
  int         settled_trigs = 0, min_settle = 999, change_cyc = 0, settle_cyc = 0;
  int         cur_len = 0, len_min = 999, len_max = 0;
  bit         have_change = 1'b0, settle_pend = 1'b0;
  logic       prev_nc = 1'b0, prev_sel = 1'b0;
  cap_state_e prev_state = ST_IDLE;
  logic       sel_q[$];
  int         fail_q[$];
  initial begin
    forever begin
      @(negedge sys_clk);
      if (mon_seen != epoch) begin
        trig_cnt = 0; done_cnt = 0; settled_trigs = 0; min_settle = 999;
        len_min = 999; len_max = 0; have_change = 1'b0; settle_pend = 1'b0;
        sel_q.delete(); fail_q.delete();
        mon_seen = epoch;
      end
      if (o_camera_sel != prev_sel) begin
        change_cyc  = cyc;
        have_change = 1'b1;
      end
      if (o_new_capture && !prev_nc) begin
        if (trig_cnt == 0) first_rise_cyc = cyc;
        trig_cnt++;
        sel_q.push_back(o_camera_sel);
        if (have_change) begin
          settled_trigs++;
          if (cyc - change_cyc < min_settle) min_settle = cyc - change_cyc;
          have_change = 1'b0;
        end
        cur_len = 1;
      end else if (o_new_capture) begin
        cur_len++;
      end
      if (!o_new_capture && prev_nc) begin
        if (cur_len < len_min) len_min = cur_len;
        if (cur_len > len_max) len_max = cur_len;
      end
      if (o_done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
      if ((o_state == ST_SETTLE) && (prev_state != ST_SETTLE)) begin
        settle_cyc  = cyc;
        settle_pend = 1'b1;
      end
      if ((o_state == ST_GAP) && (prev_state != ST_GAP) && settle_pend) begin
        fail_q.push_back(cyc - settle_cyc);
        settle_pend = 1'b0;
      end
      prev_nc    = o_new_capture;
      prev_sel   = o_camera_sel;
      prev_state = o_state;
    end
  end

  // driver tasks
  task automatic start_burst(input logic [CNT_W-1:0] frames, input logic [1:0] mode,
                             input logic [31:0] gap, input logic [31:0] tmo,
                             input logic with_abort);
    epoch++;
    @(negedge sys_clk);
    i_cfg_frames        = frames;
    i_cfg_mode          = mode;
    i_cfg_gap           = gap;
    i_cfg_start_timeout = tmo;
    i_start             = 1'b1;
    i_abort             = with_abort;
    start_cyc           = cyc;
    @(negedge sys_clk);
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (!o_done) check_val(tag, 32'd0, 32'd1);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic wait_state(input cap_state_e st, input string tag, input int budget);
    int n = 0;
    while (o_state != st && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (o_state != st) check_val(tag, 32'(o_state), 32'(st));
  endtask

  task automatic compare_sel(input string tag);
    check_val({tag, "_count"}, sel_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sel_q.size(); i++) begin
      check_val(tag, 32'(sel_q[i]), exp_q[i]);
    end
    exp_q.delete();
  endtask

  // stimulus
  initial begin
    sys_rst = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_serde_locked = 1'b1;
    i_cfg_frames = '0; i_cfg_mode = 2'd0; i_cfg_gap = '0; i_cfg_start_timeout = '0;
    for (int i = 0; i < 8; i++) dma_plan[i] = 1;
    repeat (3) @(negedge sys_clk);

    // reset state
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_done", 32'(o_done), 32'd0);
    check_val("rst_new_capture", 32'(o_new_capture), 32'd0);
    check_val("rst_sel", 32'(o_camera_sel), 32'd0);
    check_val("rst_aborted", 32'(o_aborted), 32'd0);
    check_val("rst_ok", 32'(o_frames_ok), 32'd0);
    check_val("rst_failed", 32'(o_frames_failed), 32'd0);
    check_val("rst_ts", o_last_frame_ts, 32'd0);
    check_val("rst_cycles", o_last_frame_cycles, 32'd0);
    check_val("rst_state", 32'(o_state), 32'(ST_IDLE));
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // T1: hawk only, 3 frames, gap 10, 100-cycle frames with dma_last
    start_burst(16'd3, 2'd0, 32'd10, 32'd1000, 1'b0);
    wait_done("t1_done_wait", 3000);
    check_val("t1_latency", 32'(first_rise_cyc - start_cyc), 32'd2);
    check_val("t1_trigs", 32'(trig_cnt), 32'd3);
    check_val("t1_ok", 32'(o_frames_ok), 32'd3);
    check_val("t1_failed", 32'(o_frames_failed), 32'd0);
    check_val("t1_done_pulses", 32'(done_cnt), 32'd1);
    check_val("t1_busy", 32'(o_busy), 32'd0);
    check_val("t1_trig_len_min", 32'(len_min), 32'd4);
    check_val("t1_trig_len_max", 32'(len_max), 32'd4);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'd0);
    compare_sel("t1_sel");
`ifdef FRAME_TIMING_EN
    check_val("t1_frame_cycles", o_last_frame_cycles, 32'd100);
    check_val("t1_ts_nonzero", 32'(o_last_frame_ts != 0), 32'd1);
`else
    check_val("t1_frame_cycles", o_last_frame_cycles, 32'd0);
    check_val("t1_ts", o_last_frame_ts, 32'd0);
`endif

    // T2: alternate starting hawk, 4 frames
    start_burst(16'd4, 2'd2, 32'd3, 32'd1000, 1'b0);
    wait_done("t2_done_wait", 3000);
    check_val("t2_trigs", 32'(trig_cnt), 32'd4);
    check_val("t2_ok", 32'(o_frames_ok), 32'd4);
    check_val("t2_failed", 32'(o_frames_failed), 32'd0);
    check_val("t2_settled_trigs", 32'(settled_trigs), 32'd3);
    check_val("t2_settle_ge16", 32'(min_settle >= 16), 32'd1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    compare_sel("t2_sel");

    // T3: camera never starts, timeout 50 from SETTLE entry
    model_en = 1'b0;
    start_burst(16'd2, 2'd2, 32'd5, 32'd50, 1'b0);
    wait_done("t3_done_wait", 1000);
    check_val("t3_failed", 32'(o_frames_failed), 32'd2);
    check_val("t3_ok", 32'(o_frames_ok), 32'd0);
    check_val("t3_trigs", 32'(trig_cnt), 32'd2);
    check_val("t3_fail_count", 32'(fail_q.size()), 32'd2);
    for (int i = 0; i < fail_q.size(); i++) check_val("t3_fail_delay", 32'(fail_q[i]), 32'd50);
    model_en = 1'b1;

    // T4: first frame without dma_last, second with dma_last on the fall cycle
    dma_plan[0] = 0;
    dma_plan[1] = 2;
    start_burst(16'd2, 2'd0, 32'd4, 32'd1000, 1'b0);
    wait_done("t4_done_wait", 2000);
    check_val("t4_failed", 32'(o_frames_failed), 32'd1);
    check_val("t4_ok", 32'(o_frames_ok), 32'd1);
    check_val("t4_trigs", 32'(trig_cnt), 32'd2);
    for (int i = 0; i < 8; i++) dma_plan[i] = 1;

    // T5: abort during WAIT_DONE of frame 1 of 5
    start_burst(16'd5, 2'd0, 32'd4, 32'd1000, 1'b0);
    wait_state(ST_WAIT_DONE, "t5_reach_wait_done", 500);
    repeat (10) @(negedge sys_clk);
    i_abort = 1'b1;
    @(negedge sys_clk);
    i_abort = 1'b0;
    wait_done("t5_done_wait", 1000);
    check_val("t5_trigs", 32'(trig_cnt), 32'd1);
    check_val("t5_ok", 32'(o_frames_ok), 32'd1);
    check_val("t5_failed", 32'(o_frames_failed), 32'd0);
    check_val("t5_aborted", 32'(o_aborted), 32'd1);
    check_val("t5_done_pulses", 32'(done_cnt), 32'd1);

    // T6: zero-frame burst
    start_burst(16'd0, 2'd0, 32'd0, 32'd0, 1'b0);
    wait_done("t6_done_wait", 20);
    check_val("t6_done_latency", 32'(done_cyc - start_cyc), 32'd1);
    check_val("t6_done_pulses", 32'(done_cnt), 32'd1);
    check_val("t6_trigs", 32'(trig_cnt), 32'd0);
    check_val("t6_busy", 32'(o_busy), 32'd0);

    // T7: abort during SETTLE finishes on the next cycle
    start_burst(16'd3, 2'd1, 32'd4, 32'd1000, 1'b0);
    wait_state(ST_SETTLE, "t7_reach_settle", 20);
    i_abort = 1'b1;
    @(negedge sys_clk);
    i_abort = 1'b0;
    check_val("t7_finish_state", 32'(o_state), 32'(ST_FINISH));
    check_val("t7_done", 32'(o_done), 32'd1);
    wait_done("t7_done_wait", 20);
    check_val("t7_aborted", 32'(o_aborted), 32'd1);
    check_val("t7_trigs", 32'(trig_cnt), 32'd0);
    check_val("t7_sel_held", 32'(o_camera_sel), 32'd1);

    // T7b: start and abort together in IDLE, start wins and clears aborted
    start_burst(16'd1, 2'd1, 32'd2, 32'd1000, 1'b1);
    wait_done("t7b_done_wait", 1000);
    check_val("t7b_aborted", 32'(o_aborted), 32'd0);
    check_val("t7b_ok", 32'(o_frames_ok), 32'd1);
    check_val("t7b_trigs", 32'(trig_cnt), 32'd1);

    // T8: reset while triggering
    start_burst(16'd3, 2'd1, 32'd4, 32'd1000, 1'b0);
    wait_state(ST_TRIGGER, "t8_reach_trigger", 50);
    #2 sys_rst = 1'b1;
    #1;
    check_val("t8_new_capture", 32'(o_new_capture), 32'd0);
    check_val("t8_busy", 32'(o_busy), 32'd0);
    check_val("t8_state", 32'(o_state), 32'(ST_IDLE));
    check_val("t8_sel", 32'(o_camera_sel), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
